// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write channels of the instruction encoder.
// Both channels use valid/ready semantics: a transfer happens on a rising
// clock edge where the producer's valid (in_valid / im_we) and the consumer's
// ready (in_ready / im_ready) are both high. The producer holds its payload
// stable until that edge, and ready never depends on valid.
interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [25:0]       in_imm;
    logic              im_we;
    logic              im_ready;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    // Request producer and instruction-memory side.
    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, im_ready,
        input  in_ready, im_we, im_addr, im_wdata
    );

    // Encoder side.
    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, im_ready,
        output in_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// Instruction encoder: packs per-field requests into 32-bit MIPS words and
// streams them into instruction memory at consecutive word addresses,
// starting at BASE_ADDR. Stops accepting once DEPTH words have been written.
module instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    instr_encoder_if.slave    bus,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_PEND  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    // Request op codes.
    localparam logic [3:0] OP_ADDU  = 4'd0;
    localparam logic [3:0] OP_SUBU  = 4'd1;
    localparam logic [3:0] OP_SLT   = 4'd2;
    localparam logic [3:0] OP_JR    = 4'd3;
    localparam logic [3:0] OP_ORI   = 4'd4;
    localparam logic [3:0] OP_LW    = 4'd5;
    localparam logic [3:0] OP_SW    = 4'd6;
    localparam logic [3:0] OP_BEQ   = 4'd7;
    localparam logic [3:0] OP_LUI   = 4'd8;
    localparam logic [3:0] OP_J     = 4'd9;
    localparam logic [3:0] OP_ADDI  = 4'd10;
    localparam logic [3:0] OP_ADDIU = 4'd11;
    localparam logic [3:0] OP_JAL   = 4'd12;

    // MIPS primary opcodes and R-type function codes.
    localparam logic [5:0] MO_SPECIAL = 6'b000000;
    localparam logic [5:0] MO_ORI     = 6'b001101;
    localparam logic [5:0] MO_LW      = 6'b100011;
    localparam logic [5:0] MO_SW      = 6'b101011;
    localparam logic [5:0] MO_BEQ     = 6'b000100;
    localparam logic [5:0] MO_LUI     = 6'b001111;
    localparam logic [5:0] MO_J       = 6'b000010;
    localparam logic [5:0] MO_JAL     = 6'b000011;
    localparam logic [5:0] MO_ADDI    = 6'b001000;
    localparam logic [5:0] MO_ADDIU   = 6'b001001;
    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUBU    = 6'b100011;
    localparam logic [5:0] FN_SLT     = 6'b101010;
    localparam logic [5:0] FN_JR      = 6'b001000;

    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

    state_t            state_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic              full_q;
    logic              err_q;

    logic              ready;
    logic              accept;
    logic              legal;
    logic [ADDR_W:0]   count_inc;
    logic              room_next;
    logic [31:0]       enc_word;

    // Canonical word for one request; shamt is always zero.
    function automatic logic [31:0] encode(
        input logic [3:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [25:0] imm
    );
        logic [15:0] imm16;
        logic [31:0] w;
        imm16 = imm[15:0];
        w = 32'd0;
        case (op)
            OP_ADDU:  w = {MO_SPECIAL, rs, rt, rd, 5'd0, FN_ADDU};
            OP_SUBU:  w = {MO_SPECIAL, rs, rt, rd, 5'd0, FN_SUBU};
            OP_SLT:   w = {MO_SPECIAL, rs, rt, rd, 5'd0, FN_SLT};
            OP_JR:    w = {MO_SPECIAL, rs, 15'd0, FN_JR};
            OP_ORI:   w = {MO_ORI, rs, rt, imm16};
            OP_LW:    w = {MO_LW, rs, rt, imm16};
            OP_SW:    w = {MO_SW, rs, rt, imm16};
            OP_BEQ:   w = {MO_BEQ, rs, rt, imm16};
            OP_LUI:   w = {MO_LUI, 5'd0, rt, imm16};
            OP_J:     w = {MO_J, imm};
            OP_ADDI:  w = {MO_ADDI, rs, rt, imm16};
            OP_ADDIU: w = {MO_ADDIU, rs, rt, imm16};
            OP_JAL:   w = {MO_JAL, imm};
            default:  w = 32'd0;
        endcase
        return w;
    endfunction

    assign legal     = (bus.in_op <= OP_JAL);
    assign enc_word  = encode(bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm);
    assign count_inc = count_q + CNT_ONE;
    // A new request may follow the pending word only if that word's write
    // still leaves room for one more.
    assign room_next = (count_inc < DEPTH_C);
    assign accept    = bus.in_valid & ready;

    // Request readiness from state and memory readiness only, never in_valid.
    always_comb begin
        ready = 1'b0;
        case (state_q)
            S_EMPTY: ready = ~full_q;
            S_PEND:  ready = bus.im_ready & room_next;
            default: ready = 1'b0;
        endcase
    end

    // Control FSM with registered write channel, counters and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            addr_q  <= BASE_A;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (clr) begin
            // Restart wins over everything: the pending word is dropped and
            // any request offered this cycle is discarded.
            state_q <= S_EMPTY;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            addr_q  <= BASE_A;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        if (legal) begin
                            wdata_q <= enc_word;
                            we_q    <= 1'b1;
                            state_q <= S_PEND;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_PEND: begin
                    if (bus.im_ready) begin
                        addr_q  <= addr_q + ADDR_ONE;
                        count_q <= count_inc;
                        if (accept && legal) begin
                            wdata_q <= enc_word;
                        end else begin
                            we_q <= 1'b0;
                            if (accept) begin
                                err_q   <= 1'b1;
                                state_q <= S_EMPTY;
                            end else if (count_inc == DEPTH_C) begin
                                full_q  <= 1'b1;
                                state_q <= S_FULL;
                            end else begin
                                state_q <= S_EMPTY;
                            end
                        end
                    end
                end
                S_FULL: begin
                    state_q <= S_FULL;
                end
                default: begin
                    state_q <= S_EMPTY;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = ready;
    assign bus.im_we    = we_q;
    assign bus.im_addr  = addr_q;
    assign bus.im_wdata = wdata_q;
    assign count        = count_q;
    assign full         = full_q;
    assign err          = err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios with literal encodings plus a
// randomized run, all compared against a transaction-level reference model.
module tb_instr_encoder;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;
    localparam int BASE   = 6;

    logic              clk;
    logic              rst;
    logic              clr;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
    logic [1:0]        dbg_state;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .bus       (bus),
        .count     (count),
        .full      (full),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Primary opcode per request op, and function codes of the SPECIAL group.
    int opc_tab [13] = '{0, 0, 0, 0, 13, 35, 43, 4, 15, 2, 8, 9, 3};
    int fn_tab  [4]  = '{33, 35, 42, 8};

    function automatic logic [31:0] ref_enc(input int op, input int rs, input int rt,
                                            input int rd, input int imm26);
        longint w;
        int imm16;
        imm16 = imm26 % 65536;
        if (op <= 2)
            w = longint'(rs) * (2 ** 21) + longint'(rt) * (2 ** 16) + longint'(rd) * (2 ** 11) + fn_tab[op];
        else if (op == 3)
            w = longint'(rs) * (2 ** 21) + fn_tab[3];
        else if (op == 8)
            w = longint'(opc_tab[op]) * (2 ** 26) + longint'(rt) * (2 ** 16) + imm16;
        else if (op == 9 || op == 12)
            w = longint'(opc_tab[op]) * (2 ** 26) + imm26;
        else
            w = longint'(opc_tab[op]) * (2 ** 26) + longint'(rs) * (2 ** 21) + longint'(rt) * (2 ** 16) + imm16;
        return 32'(w);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_at(input int k);
        return ADDR_W'((BASE + k) % (2 ** ADDR_W));
    endfunction

    // Scoreboard: the queue holds words accepted but not yet written; at most
    // one is outstanding, so "pending" is simply a non-empty queue.
    logic [31:0] exp_q[$];
    int          m_count = 0;
    logic        m_err   = 1'b0;

    always @(negedge clk) begin
        logic pending;
        logic exp_ready;
        if (rst) begin
            exp_q.delete();
            m_count = 0;
            m_err   = 1'b0;
        end else begin
            pending   = (exp_q.size() != 0);
            exp_ready = pending ? (bus.im_ready && (m_count + 1 < DEPTH)) : (m_count < DEPTH);
            check("im_we", 32'(bus.im_we), 32'(pending));
            check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
            check("count", 32'(count), 32'(m_count));
            check("full", 32'(full), 32'(m_count == DEPTH));
            check("err", 32'(err), 32'(m_err));
            if (pending) begin
                check("im_addr", 32'(bus.im_addr), 32'(addr_at(m_count)));
                check("im_wdata", bus.im_wdata, exp_q[0]);
            end
            if (clr) begin
                exp_q.delete();
                m_count = 0;
                m_err   = 1'b0;
            end else begin
                if (pending && bus.im_ready) begin
                    void'(exp_q.pop_front());
                    m_count++;
                end
                if (bus.in_valid && exp_ready) begin
                    if (bus.in_op <= 4'd12)
                        exp_q.push_back(ref_enc(int'(bus.in_op), int'(bus.in_rs), int'(bus.in_rt),
                                                int'(bus.in_rd), int'(bus.in_imm)));
                    else
                        m_err = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic req(input logic v, input int op, input int rs, input int rt,
                       input int rd, input int imm);
        bus.in_valid = v;
        bus.in_op    = 4'(op);
        bus.in_rs    = 5'(rs);
        bus.in_rt    = 5'(rt);
        bus.in_rd    = 5'(rd);
        bus.in_imm   = 26'(imm);
    endtask

    task automatic do_clr();
        clr          = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        clr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        clr = 1'b0;
        bus.im_ready = 1'b0;
        req(1'b0, 0, 0, 0, 0, 0);

        // Reset values.
        #3;
        check("rst_im_we", 32'(bus.im_we), 32'd0);
        check("rst_im_wdata", bus.im_wdata, 32'd0);
        check("rst_im_addr", 32'(bus.im_addr), 32'(BASE));
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        #10 rst = 1'b0;
        tick();

        // Single ADDU: one-clock latency to the write strobe.
        bus.im_ready = 1'b1;
        req(1'b1, 0, 1, 2, 3, 0);
        tick();
        bus.in_valid = 1'b0;
        at_neg();
        check("addu_we", 32'(bus.im_we), 32'd1);
        check("addu_addr", 32'(bus.im_addr), 32'(addr_at(0)));
        check("addu_word", bus.im_wdata, 32'h0022_1821);
        tick();
        at_neg();
        check("addu_count", 32'(count), 32'd1);

        // Back-to-back stream ORI, LW, JAL.
        do_clr();
        req(1'b1, 4, 0, 8, 0, 'h1234);
        tick();
        req(1'b1, 5, 29, 9, 0, 'hFFFC);
        at_neg();
        check("ori_word", bus.im_wdata, 32'h3408_1234);
        check("ori_addr", 32'(bus.im_addr), 32'(addr_at(0)));
        tick();
        req(1'b1, 12, 0, 0, 0, 'h0100000);
        at_neg();
        check("lw_word", bus.im_wdata, 32'h8FA9_FFFC);
        check("lw_addr", 32'(bus.im_addr), 32'(addr_at(1)));
        tick();
        bus.in_valid = 1'b0;
        at_neg();
        check("jal_word", bus.im_wdata, 32'h0C10_0000);
        check("jal_addr", 32'(bus.im_addr), 32'(addr_at(2)));
        tick();
        at_neg();
        check("stream_count", 32'(count), 32'd3);

        // Memory stall for 3 clocks with a competing request held valid.
        do_clr();
        bus.im_ready = 1'b0;
        req(1'b1, 10, 3, 4, 0, 'h8000);
        tick();
        req(1'b1, 4, 1, 1, 0, 'h0055);
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("stall_word", bus.im_wdata, 32'h2064_8000);
            check("stall_ready", 32'(bus.in_ready), 32'd0);
            check("stall_count", 32'(count), 32'd0);
            tick();
        end
        bus.im_ready = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        at_neg();
        check("stall_done_count", 32'(count), 32'd1);
        check("stall_done_we", 32'(bus.im_we), 32'd0);

        // Fill to DEPTH with more requests offered than fit.
        do_clr();
        for (int i = 0; i < 8; i++) begin
            req(1'b1, $urandom_range(0, 12), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 32'h3FFFFFF));
            tick();
        end
        at_neg();
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'(DEPTH));
        check("fill_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;

        // Illegal op, then BEQ lands at the same address.
        do_clr();
        req(1'b1, 15, 1, 2, 3, 4);
        tick();
        bus.in_valid = 1'b0;
        at_neg();
        check("illegal_err", 32'(err), 32'd1);
        check("illegal_we", 32'(bus.im_we), 32'd0);
        req(1'b1, 7, 1, 2, 0, 3);
        tick();
        bus.in_valid = 1'b0;
        at_neg();
        check("beq_word", bus.im_wdata, 32'h1022_0003);
        check("beq_addr", 32'(bus.im_addr), 32'(addr_at(0)));
        tick();

        // Asynchronous reset while a word is pending.
        do_clr();
        req(1'b1, 13, 0, 0, 0, 0);
        tick();
        req(1'b1, 0, 4, 5, 6, 0);
        tick();
        req(1'b1, 4, 7, 8, 0, 'h00FF);
        tick();
        bus.in_valid = 1'b0;
        bus.im_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_we", 32'(bus.im_we), 32'd0);
        check("arst_addr", 32'(bus.im_addr), 32'(BASE));
        check("arst_count", 32'(count), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_wdata", bus.im_wdata, 32'd0);
        at_neg();
        @(posedge clk);
        #2 rst = 1'b0;

        // clr with a pending word, a ready memory and a valid request.
        req(1'b1, 1, 9, 10, 11, 0);
        tick();
        clr          = 1'b1;
        bus.im_ready = 1'b1;
        req(1'b1, 2, 1, 1, 1, 0);
        tick();
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        at_neg();
        check("clr_we", 32'(bus.im_we), 32'd0);
        check("clr_count", 32'(count), 32'd0);
        check("clr_addr", 32'(bus.im_addr), 32'(BASE));
        tick();

        // Randomized traffic checked by the scoreboard.
        for (int i = 0; i < 800; i++) begin
            req($urandom_range(0, 9) < 7, $urandom_range(0, 15), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 32'h3FFFFFF));
            bus.im_ready = ($urandom_range(0, 9) < 7);
            clr          = ($urandom_range(0, 29) == 0);
            tick();
        end
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
